// File: rtl/ecdsa_pkg.sv
// Shared definitions for the EC scalar-multiplier front end: curve order,
// frame geometry and the loader state encoding.
package ecdsa_pkg;

    localparam logic [255:0] CURVE_N =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

    localparam int WORDS_PER_COORD = 8;
    localparam int WORDS_IN        = 24;
    localparam int WORDS_OUT       = 16;

    localparam logic [4:0] PY_FIRST_IDX = 5'(WORDS_PER_COORD);
    localparam logic [4:0] K_FIRST_IDX  = 5'(2 * WORDS_PER_COORD);
    localparam logic [4:0] LAST_IN_IDX  = 5'(WORDS_IN - 1);
    localparam logic [3:0] LAST_OUT_IDX = 4'(WORDS_OUT - 1);

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_CHECK = 3'd1,
        ST_FIRE  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SEND  = 3'd4
    } loader_state_e;

    // Pick 32-bit word idx (LSW = 0) out of the packed {Ry, Rx} result.
    function automatic logic [31:0] word_of(input logic [511:0] vec, input logic [3:0] idx);
        return vec[{idx, 5'b00000} +: 32];
    endfunction

endpackage

// File: rtl/k_range_check.sv
// Combinational scalar range test: valid when 0 < k < N (unsigned 256-bit).
module k_range_check
    import ecdsa_pkg::*;
#(
    parameter logic [255:0] N = CURVE_N
) (
    input  logic [255:0] i_k,
    output logic         o_valid
);

    assign o_valid = (i_k != 256'd0) && (i_k < N);

endmodule

// File: rtl/scalar_mul_loader.sv
// Word-serial loader/unloader wrapped around the 256-bit EC scalar multiplier.
// Build macro KRANGE_CHECK_EN enables the 0 < k < N check and the err pulse.
module scalar_mul_loader
    import ecdsa_pkg::*;
#(
    parameter logic [255:0] N = CURVE_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic         err,
    output logic         busy,
    output logic [255:0] mul_Px,
    output logic [255:0] mul_Py,
    output logic [255:0] mul_k,
    output logic         mul_in_valid,
    input  logic [255:0] mul_Rx,
    input  logic [255:0] mul_Ry,
    input  logic         mul_out_valid
);

    loader_state_e r_state;
    loader_state_e w_next_state;

    logic [4:0]   r_in_cnt;
    logic [3:0]   r_out_cnt;
    logic [255:0] r_px;
    logic [255:0] r_py;
    logic [255:0] r_k;
    logic [511:0] r_res;
    logic [31:0]  r_out_data;
    logic         r_out_last;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_err;
    logic         r_busy;
    logic         r_mul_in_valid;

    logic         w_in_fire;
    logic         w_out_fire;
    logic         w_resp;
    logic         w_enter_load;
    logic         w_k_ok;
    logic [7:0]   w_slot;
    logic [3:0]   w_out_next_idx;

    assign w_in_fire      = in_valid && r_in_ready;
    assign w_out_fire     = r_out_valid && out_ready;
    assign w_resp         = (r_state == ST_WAIT) && mul_out_valid;
    assign w_enter_load   = (r_state != ST_LOAD) && (w_next_state == ST_LOAD);
    assign w_slot         = {r_in_cnt[2:0], 5'b00000};
    assign w_out_next_idx = r_out_cnt + 4'd1;

`ifdef KRANGE_CHECK_EN
    k_range_check #(.N(N)) u_k_range_check (
        .i_k     (r_k),
        .o_valid (w_k_ok)
    );
`else
    // Without the range check every scalar is forwarded; CHECK still costs one cycle.
    assign w_k_ok = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_in_fire && (r_in_cnt == LAST_IN_IDX)) begin
                    w_next_state = ST_CHECK;
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_CHECK: begin
                if (w_k_ok) begin
                    w_next_state = ST_FIRE;
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_FIRE: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (mul_out_valid) begin
                    w_next_state = ST_SEND;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_SEND: begin
                if (w_out_fire && (r_out_cnt == LAST_OUT_IDX)) begin
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_SEND;
                end
            end
            default: w_next_state = ST_LOAD;
        endcase
    end

    // Handshake and status flags, registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_busy         <= 1'b0;
            r_mul_in_valid <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_in_ready     <= (w_next_state == ST_LOAD);
            r_out_valid    <= (w_next_state == ST_SEND);
            r_busy         <= (w_next_state != ST_LOAD);
            r_mul_in_valid <= (w_next_state == ST_FIRE);
            r_err          <= (r_state == ST_CHECK) && !w_k_ok;
        end
    end

    // Word counters, cleared whenever the FSM returns to LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_cnt  <= 5'd0;
            r_out_cnt <= 4'd0;
        end else if (w_enter_load) begin
            r_in_cnt  <= 5'd0;
            r_out_cnt <= 4'd0;
        end else begin
            if (w_in_fire) begin
                r_in_cnt <= r_in_cnt + 5'd1;
            end
            if (w_out_fire) begin
                r_out_cnt <= w_out_next_idx;
            end
        end
    end

    // Operand assembly: each accepted word lands in its 32-bit slot of Px, Py or k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_px <= '0;
            r_py <= '0;
            r_k  <= '0;
        end else if (w_in_fire) begin
            if (r_in_cnt < PY_FIRST_IDX) begin
                r_px[w_slot +: 32] <= in_data;
            end else if (r_in_cnt < K_FIRST_IDX) begin
                r_py[w_slot +: 32] <= in_data;
            end else begin
                r_k[w_slot +: 32] <= in_data;
            end
        end
    end

    // Result capture and output word sequencing; data only moves on an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res      <= '0;
            r_out_data <= 32'd0;
            r_out_last <= 1'b0;
        end else if (w_resp) begin
            r_res      <= {mul_Ry, mul_Rx};
            r_out_data <= mul_Rx[31:0];
            r_out_last <= 1'b0;
        end else if (w_out_fire) begin
            if (r_out_cnt == LAST_OUT_IDX) begin
                r_out_last <= 1'b0;
            end else begin
                r_out_data <= word_of(r_res, w_out_next_idx);
                r_out_last <= (w_out_next_idx == LAST_OUT_IDX);
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_last     = r_out_last;
    assign err          = r_err;
    assign busy         = r_busy;
    assign mul_Px       = r_px;
    assign mul_Py       = r_py;
    assign mul_k        = r_k;
    assign mul_in_valid = r_mul_in_valid;

endmodule

// File: tb/tb_scalar_mul_loader.sv
// Bench for scalar_mul_loader: drives 24-word frames, plays the multiplier, and
// compares the streamed result against a secp256k1 model plus frame-level rules.
module tb_scalar_mul_loader;
    import ecdsa_pkg::*;

    localparam logic [255:0] P   = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] GX  = 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
    localparam logic [255:0] GY  = 256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
    localparam logic [255:0] RX2 = 256'hC6047F94_41ED7D6D_3045406E_95C07CD8_5C778E4B_8CEF3CA7_ABAC09B9_5C709EE5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = 32'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic         out_last;
    logic         err;
    logic         busy;
    logic [255:0] mul_Px, mul_Py, mul_k;
    logic         mul_in_valid;
    logic [255:0] mul_Rx = '0;
    logic [255:0] mul_Ry = '0;
    logic         mul_out_valid = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Results of the last run_tx call
    int           t_fire, t_err, t_beats, t_last_bad, t_stall_bad;
    int           t_fire_lat, t_err_lat, t_ov_lat;
    bit           t_ops_ok, t_busy_ok, t_rdy_after_err, t_timeout;
    logic [511:0] t_got;

    always #5 clk = ~clk;

    scalar_mul_loader dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .err(err), .busy(busy),
        .mul_Px(mul_Px), .mul_Py(mul_Py), .mul_k(mul_k), .mul_in_valid(mul_in_valid),
        .mul_Rx(mul_Rx), .mul_Ry(mul_Ry), .mul_out_valid(mul_out_valid)
    );

    // ---------------- reference arithmetic ----------------
    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit k_expected_ok(input logic [255:0] k);
`ifdef KRANGE_CHECK_EN
        return (k != 256'd0) && (k < CURVE_N);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] t;
        logic [511:0] m;
        t = {256'd0, a} * {256'd0, b};
        m = t % {256'd0, P};
        return m[255:0];
    endfunction

    function automatic logic [255:0] addmod(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[255:0];
    endfunction

    function automatic logic [255:0] submod(input logic [255:0] a, input logic [255:0] b);
        return (a >= b) ? (a - b) : (a + (P - b));
    endfunction

    function automatic logic [255:0] invmod(input logic [255:0] a);
        logic [255:0] e, r, base;
        e = P - 256'd2;
        r = 256'd1;
        base = a;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = mulmod(r, base);
            base = mulmod(base, base);
        end
        return r;
    endfunction

    task automatic ec_double(input logic [255:0] x, input logic [255:0] y,
                             output logic [255:0] x3, output logic [255:0] y3);
        logic [255:0] lam;
        lam = mulmod(mulmod(256'd3, mulmod(x, x)), invmod(addmod(y, y)));
        x3  = submod(mulmod(lam, lam), addmod(x, x));
        y3  = submod(mulmod(lam, submod(x, x3)), y);
    endtask

    // ---------------- frame driver + multiplier responder + sink ----------------
    task automatic run_tx(input logic [255:0] px, input logic [255:0] py, input logic [255:0] k,
                          input logic [255:0] rx, input logic [255:0] ry,
                          input bit stall, input bit stray);
        logic [767:0] frame;
        logic [31:0]  hold_d;
        logic         hold_l;
        bit           prev_stall;
        int           i, cyc, resp_cyc, pulse_cyc, done_cyc;
        frame = {k, py, px};
        t_fire = 0; t_err = 0; t_beats = 0; t_last_bad = 0; t_stall_bad = 0;
        t_fire_lat = -1; t_err_lat = -1; t_ov_lat = -1;
        t_ops_ok = 1'b1; t_busy_ok = 1'b0; t_rdy_after_err = 1'b0; t_timeout = 1'b0;
        t_got = '0;
        hold_d = 32'd0; hold_l = 1'b0; prev_stall = 1'b0;
        i = 0; cyc = 0;
        while (i < 24 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            mul_out_valid = 1'b0;
            if (stray && i == 5) begin
                mul_out_valid = 1'b1; mul_Rx = rand256(); mul_Ry = rand256();
            end
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = frame[i*32 +: 32];
            if (in_valid && in_ready) i++;
        end
        if (i < 24) begin
            t_timeout = 1'b1;
            in_valid = 1'b0;
            return;
        end
        resp_cyc = -1; pulse_cyc = -1; done_cyc = -1;
        for (cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            mul_out_valid = 1'b0;
            mul_Rx = rand256(); mul_Ry = rand256();
            in_valid = (in_ready === 1'b0) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data  = $urandom;
            if (cyc == 0) begin
                t_busy_ok = (busy === 1'b1) && (in_ready === 1'b0) && (out_valid === 1'b0);
                if (stray) mul_out_valid = 1'b1;
            end
            if (mul_in_valid === 1'b1) begin
                t_fire++;
                t_fire_lat = cyc;
                resp_cyc = cyc + $urandom_range(1, 12);
            end
            if (resp_cyc >= 0 && cyc <= resp_cyc) begin
                if (mul_Px !== px || mul_Py !== py || mul_k !== k) t_ops_ok = 1'b0;
            end
            if (err === 1'b1) begin
                t_err++;
                t_err_lat = cyc;
                t_rdy_after_err = in_ready;
            end
            if (cyc == resp_cyc) begin
                mul_out_valid = 1'b1; mul_Rx = rx; mul_Ry = ry;
                pulse_cyc = cyc;
            end
            if (out_valid === 1'b1) begin
                if (t_ov_lat < 0) t_ov_lat = cyc - pulse_cyc;
                if (prev_stall && (out_data !== hold_d || out_last !== hold_l)) t_stall_bad++;
                out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_ready) begin
                    if (t_beats < 16) t_got[t_beats*32 +: 32] = out_data;
                    if (out_last !== 1'(t_beats == 15)) t_last_bad++;
                    t_beats++;
                end
                prev_stall = !out_ready;
                hold_d = out_data;
                hold_l = out_last;
            end else begin
                out_ready  = 1'($urandom_range(0, 1));
                prev_stall = 1'b0;
            end
            if (done_cyc < 0 && (t_beats >= 16 || t_err > 0)) done_cyc = cyc;
            if (done_cyc >= 0 && cyc >= done_cyc + 6) break;
        end
        if (done_cyc < 0) t_timeout = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; mul_out_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({in_ready, out_valid, out_last, err, busy, mul_in_valid} !== 6'd0) begin n_bad++; $display("FAIL reset_flags: got %b expected 000000", {in_ready, out_valid, out_last, err, busy, mul_in_valid}); end
        n_cmp++; if ({out_data, mul_Px, mul_Py, mul_k} !== '0) begin n_bad++; $display("FAIL reset_data: got out_data=%h k=%h expected 0", out_data, mul_k); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_before_clk: got %b expected 0", in_ready); end
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after_clk: got %b expected 1", in_ready); end
    endtask

    task automatic test_k1();
        run_tx(GX, GY, 256'd1, GX, GY, 1'b0, 1'b0);
        n_cmp++; if (t_timeout !== 1'b0) begin n_bad++; $display("FAIL k1_timeout: got %b expected 0", t_timeout); end
        n_cmp++; if (t_fire !== 1) begin n_bad++; $display("FAIL k1_fire_count: got %0d expected 1", t_fire); end
        n_cmp++; if (t_fire_lat !== 1) begin n_bad++; $display("FAIL k1_fire_latency: got %0d expected 1", t_fire_lat); end
        n_cmp++; if (t_busy_ok !== 1'b1) begin n_bad++; $display("FAIL k1_check_cycle_flags: got %b expected 1", t_busy_ok); end
        n_cmp++; if (t_ops_ok !== 1'b1) begin n_bad++; $display("FAIL k1_operands: got %b expected 1", t_ops_ok); end
        n_cmp++; if (t_ov_lat !== 1) begin n_bad++; $display("FAIL k1_out_latency: got %0d expected 1", t_ov_lat); end
        n_cmp++; if (t_beats !== 16) begin n_bad++; $display("FAIL k1_beats: got %0d expected 16", t_beats); end
        n_cmp++; if (t_got !== {GY, GX}) begin n_bad++; $display("FAIL k1_result: got %h expected %h", t_got, {GY, GX}); end
        n_cmp++; if (t_last_bad !== 0) begin n_bad++; $display("FAIL k1_out_last: got %0d bad beats expected 0", t_last_bad); end
        n_cmp++; if (t_err !== 0) begin n_bad++; $display("FAIL k1_err: got %0d expected 0", t_err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL k1_busy_idle: got %b expected 0", busy); end
    endtask

    task automatic test_k2();
        logic [255:0] x2, y2;
        ec_double(GX, GY, x2, y2);
        run_tx(GX, GY, 256'd2, x2, y2, 1'b0, 1'b0);
        n_cmp++; if (t_fire !== 1) begin n_bad++; $display("FAIL k2_fire_count: got %0d expected 1", t_fire); end
        n_cmp++; if (t_got[255:0] !== RX2) begin n_bad++; $display("FAIL k2_rx: got %h expected %h", t_got[255:0], RX2); end
        n_cmp++; if (t_got[511:256] !== y2) begin n_bad++; $display("FAIL k2_ry: got %h expected %h", t_got[511:256], y2); end
    endtask

    task automatic test_krange();
        logic [255:0] ks [6];
        logic [255:0] rx, ry;
        bit ok;
        ks[0] = 256'd0;
        ks[1] = CURVE_N;
        ks[2] = CURVE_N - 256'd1;
        ks[3] = CURVE_N + 256'($urandom_range(1, 1000));
        ks[4] = {1'b0, rand256() >> 1} | 256'd1;
        ks[5] = ~256'd0;
        for (int j = 0; j < 6; j++) begin
            rx = rand256(); ry = rand256();
            ok = k_expected_ok(ks[j]);
            run_tx(rand256(), rand256(), ks[j], rx, ry, 1'b0, 1'b0);
            n_cmp++; if (t_err !== (ok ? 0 : 1)) begin n_bad++; $display("FAIL krange_err[%0d]: got %0d expected %0d", j, t_err, ok ? 0 : 1); end
            n_cmp++; if (t_fire !== (ok ? 1 : 0)) begin n_bad++; $display("FAIL krange_fire[%0d]: got %0d expected %0d", j, t_fire, ok ? 1 : 0); end
            n_cmp++; if (t_beats !== (ok ? 16 : 0)) begin n_bad++; $display("FAIL krange_beats[%0d]: got %0d expected %0d", j, t_beats, ok ? 16 : 0); end
            if (ok) begin
                n_cmp++; if (t_got !== {ry, rx}) begin n_bad++; $display("FAIL krange_result[%0d]: got %h expected %h", j, t_got, {ry, rx}); end
            end else begin
                n_cmp++; if (t_err_lat !== 1) begin n_bad++; $display("FAIL krange_err_latency[%0d]: got %0d expected 1", j, t_err_lat); end
                n_cmp++; if (t_rdy_after_err !== 1'b1) begin n_bad++; $display("FAIL krange_ready_at_err[%0d]: got %b expected 1", j, t_rdy_after_err); end
            end
        end
    endtask

    task automatic test_stall();
        logic [255:0] k, rx, ry;
        for (int j = 0; j < 3; j++) begin
            k = rand256(); k[255] = 1'b0; k[0] = 1'b1;
            rx = rand256(); ry = rand256();
            run_tx(rand256(), rand256(), k, rx, ry, 1'b1, 1'b0);
            n_cmp++; if (t_beats !== 16) begin n_bad++; $display("FAIL stall_beats[%0d]: got %0d expected 16", j, t_beats); end
            n_cmp++; if (t_got !== {ry, rx}) begin n_bad++; $display("FAIL stall_result[%0d]: got %h expected %h", j, t_got, {ry, rx}); end
            n_cmp++; if (t_stall_bad !== 0) begin n_bad++; $display("FAIL stall_hold[%0d]: got %0d changes expected 0", j, t_stall_bad); end
            n_cmp++; if (t_last_bad !== 0) begin n_bad++; $display("FAIL stall_last[%0d]: got %0d bad beats expected 0", j, t_last_bad); end
        end
    endtask

    task automatic test_mid_reset();
        logic [767:0] junk;
        int i, cyc;
        bit quiet;
        junk = {rand256(), rand256(), rand256()};
        i = 0; cyc = 0;
        while (i < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            in_valid = 1'b1;
            in_data  = junk[i*32 +: 32];
            if (in_ready) i++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) quiet = 1'b0;
        end
        n_cmp++; if (quiet !== 1'b1) begin n_bad++; $display("FAIL midreset_quiet: got %b expected 1", quiet); end
        n_cmp++; if (mul_Px !== 256'd0) begin n_bad++; $display("FAIL midreset_operands: got %h expected 0", mul_Px); end
        rst_n = 1'b1;
        run_tx(GX, GY, 256'd1, GX, GY, 1'b0, 1'b0);
        n_cmp++; if (t_got !== {GY, GX}) begin n_bad++; $display("FAIL midreset_result: got %h expected %h", t_got, {GY, GX}); end
        n_cmp++; if (t_err !== 0 || t_fire !== 1) begin n_bad++; $display("FAIL midreset_err_fire: got err=%0d fire=%0d expected 0/1", t_err, t_fire); end
    endtask

    task automatic test_stray();
        logic [255:0] rx, ry;
        rx = rand256(); ry = rand256();
        run_tx(GX, GY, 256'd1, rx, ry, 1'b0, 1'b1);
        n_cmp++; if (t_beats !== 16) begin n_bad++; $display("FAIL stray_beats: got %0d expected 16", t_beats); end
        n_cmp++; if (t_got !== {ry, rx}) begin n_bad++; $display("FAIL stray_result: got %h expected %h", t_got, {ry, rx}); end
        n_cmp++; if (t_ov_lat !== 1) begin n_bad++; $display("FAIL stray_out_latency: got %0d expected 1", t_ov_lat); end
    endtask

    task automatic test_back_to_back();
        logic [255:0] px, py, k, rx, ry;
        for (int j = 0; j < 3; j++) begin
            px = rand256(); py = rand256(); rx = rand256(); ry = rand256();
            k = rand256(); k[255] = 1'b0; k[3] = 1'b1;
            run_tx(px, py, k, rx, ry, 1'b1, 1'b0);
            n_cmp++; if (t_ops_ok !== 1'b1) begin n_bad++; $display("FAIL b2b_operands[%0d]: got %b expected 1", j, t_ops_ok); end
            n_cmp++; if (t_got !== {ry, rx} || t_beats !== 16) begin n_bad++; $display("FAIL b2b_result[%0d]: got %h (%0d beats) expected %h", j, t_got, t_beats, {ry, rx}); end
        end
    endtask

    initial begin
        test_reset();
        test_k1();
        test_k2();
        test_krange();
        test_stall();
        test_mid_reset();
        test_stray();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/scalar_mul_loader.md
# scalar_mul_loader

Word-serial front end for the 256-bit elliptic-curve scalar multiplier. It assembles Px, Py and k from a 32-bit input stream and range-checks k against the curve order. It then issues a single-cycle start to the multiplier, waits for its one-cycle result pulse, captures Rx/Ry and returns them as a 32-bit output stream. It sits directly upstream of the multiplier and also terminates its result.

## Interface
- N, default 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141 (secp256k1 order): upper bound for k.
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input word valid.
- in_ready  output  1  loader accepts a word; transfer when in_valid && in_ready.
- in_data  input  32  operand word.
- out_valid  output  1  result word valid.
- out_ready  input  1  sink accepts a result word.
- out_data  output  32  result word.
- out_last  output  1  marks the 16th result word.
- err  output  1  one-cycle pulse when k is rejected.
- busy  output  1  high from CHECK through the last SEND beat.
- mul_Px, mul_Py, mul_k  output  256 each  operands to the multiplier; held stable from FIRE to the end of WAIT.
- mul_in_valid  output  1  one-cycle start pulse.
- mul_Rx, mul_Ry  input  256 each  multiplier result.
- mul_out_valid  input  1  one-cycle result-valid pulse from the multiplier.

## Operation
- Frame: exactly 24 accepted words.
  - Px words 0–7, least-significant word first.
  - Py words 8–15, same order.
  - k words 16–23, same order.
- States and transitions:
  - LOAD: in_ready=1. A 5-bit word counter increments on each accept. When word 23 is accepted, go to CHECK.
  - CHECK: one cycle. k is valid iff 0 < k < N, as an unsigned 256-bit compare. Invalid: pulse err and go to LOAD. Valid: go to FIRE.
  - FIRE: one cycle with mul_in_valid=1. Go to WAIT.
  - WAIT: wait for mul_out_valid. When it is seen, capture mul_Rx/mul_Ry into internal registers in that same cycle and go to SEND.
  - SEND: out_valid=1. Emit Rx words 0–7, then Ry words 0–7, each least-significant word first. A word advances only on out_valid && out_ready. out_last=1 on word 15. After word 15 is accepted, go to LOAD.
- Input and output word counters clear on entry to LOAD.
- Boundary conditions:
  - in_valid outside LOAD is ignored; in_ready is 0 there.
  - mul_out_valid outside WAIT is ignored.
  - out_ready low stalls SEND; out_data and out_last hold unchanged.
  - k = N-1 is accepted. k = N and k = 0 are rejected.
  - A rejected frame produces no output words and no mul_in_valid.
- There is no timeout in WAIT. The multiplier always completes, after roughly 256 to 512 point-add operations.

## Timing
- Reset values:
  - state=LOAD.
  - in_ready=0, out_valid=0, out_last=0, err=0, busy=0, mul_in_valid=0.
  - out_data=0, and all mul_* outputs and operand registers = 0.
- in_ready is registered. It rises in the first clock after rst_n deasserts.
- Latency from the last input accept:
  - CHECK on the next cycle.
  - err or FIRE one cycle after that.
  - First out_valid one cycle after mul_out_valid.
- Full frame turnaround: 24 input beats + 2 + multiplier latency + 1 + 16 output beats, at minimum.
- Reset mid-operation: all state is discarded and no err is emitted. The next 24 accepted words form a fresh frame.

## Configuration
- KRANGE_CHECK_EN
  - Defined: CHECK performs the 0 < k < N test and err is functional.
  - Undefined: CHECK always passes and err is tied to 0. The one-cycle CHECK state is retained, so latency is identical in both builds.

## Structure
- Shared package ecdsa_pkg holds:
  - the curve-order constant N;
  - word-count constants (8 words per coordinate, 24 words in, 16 words out);
  - the loader state enum.
- Sub-module k_range_check: combinational 256-bit compare, output valid = (k != 0) && (k < N). It is instantiated only under KRANGE_CHECK_EN.

## Test plan
- G = (79BE667E…16F81798, 483ADA77…FB10D4B8), k=1 -> exactly one mul_in_valid, output stream equals G, out_last on beat 16.
- Same G, k=2 -> Rx = C6047F94…5C709EE5; Ry matches the golden model.
- k=0, then k=N -> err pulse for each, no mul_in_valid, no out_valid; in_ready is 1 again on the next cycle. k=N-1 -> FIRE occurs.
- Random out_ready toggling during SEND -> out_data/out_last stable while stalled; exactly 16 beats delivered in order.
- Assert rst_n low after 10 input words, release, send a full k=1 frame -> correct G result; no err and no output from the partial frame.
- Stray mul_out_valid pulses in LOAD and CHECK -> ignored; captured result comes only from the pulse in WAIT.
